j11memctl: RTL and testbench
============================

# j11memctl

Memory-side responder for the J11 bus controller's `memreq` strobe interface. It captures one 16-bit CPU memory cycle and range-checks the byte address. In-range cycles are converted to a 32-bit word request on a valid/ready downstream port. The selected halfword, or an error, is returned as a single-cycle `memack`. It sits between the bus controller and the board memory fabric (BRAM/DDR bridge), and its error path is what produces non-existent-memory traps.

## Interface
Parameters:
- `MEMTOP`, default 22'o10000000 (2 MiB): first non-existent byte address. Any `memaddr >= MEMTOP` is an error.
- `TIMEOUT`, default 255: maximum number of cycles `dvalid` may wait for `dready`. Range 1..255.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset, synchronous, active-low.
- `memreq` in 1: single-cycle request strobe. `memwr`/`memaddr`/`memwdata`/`memwstrb` are valid in the same cycle.
- `memwr` in 1: 1 = write, 0 = read.
- `memaddr` in 22: byte address. Bit 0 is ignored.
- `memwdata` in 16: write data.
- `memwstrb` in 2: byte enables, [1] = high byte.
- `memack` out 1: single-cycle completion pulse.
- `memrdata` out 16: read data, valid with `memack`.
- `memerr` out 1: error flag, valid with `memack`.
- `busy` out 1: transaction in progress.
- `dvalid` out 1: downstream request valid.
- `dready` in 1: downstream request accepted.
- `dwr` out 1: downstream write.
- `daddr` out 20: 32-bit word address, equal to `memaddr[21:2]`.
- `dwdata` out 32: downstream write data.
- `dwstrb` out 4: downstream byte enables.
- `drvalid` in 1: downstream response valid, single cycle.
- `drdata` in 32: downstream read data.
- `derr` in 1: downstream error, valid with `drvalid`.

## Operation
- Capture: on `memreq` in IDLE, register `memwr`, `memaddr`, `memwdata` and `memwstrb`. `memreq` in any other state is ignored; the bus controller never issues a second request before `memack`.
- FSM states and transitions:
  - IDLE -> ERR when `memreq` and address >= `MEMTOP`.
  - IDLE -> REQ when `memreq` and address < `MEMTOP`.
  - REQ -> WAIT on `dvalid & dready`.
  - REQ -> ERR when the timeout counter reaches `TIMEOUT`.
  - WAIT -> DONE on `drvalid`.
  - ERR -> IDLE.
  - DONE -> IDLE.
- Word/halfword mapping uses `h = addr[1]`:
  - `dwdata = {wdata, wdata}`.
  - Write: `dwstrb = h ? {wstrb, 2'b00} : {2'b00, wstrb}`.
  - Read: `dwstrb = 4'b0000`.
  - `memrdata = h ? drdata[31:16] : drdata[15:0]`, latched on `drvalid`.
- `memerr` is set in two cases. For an ERR-state ack, `memerr = 1` and `memrdata = 0`. For a DONE-state ack, `memerr` equals the `derr` latched with the response.
- Writes also return the latched halfword on `memrdata`. The bus controller ignores it.
- Timeout counter:
  - 8-bit, cleared on entry to REQ, incremented each REQ cycle without `dready`.
  - When the count reaches `TIMEOUT`, `dvalid` is withdrawn in that same cycle. This is legal on the downstream port, because a request is committed only on `dvalid & dready`.
  - Once accepted, the downstream always responds, so WAIT has no timeout.
- `busy` is 1 in every state except IDLE.

## Timing
- Reset (`rstn = 0` at a clock edge) puts the FSM in IDLE and sets `memack = 0`, `memerr = 0`, `memrdata = 0`, `dvalid = 0`, `dwr = 0`, `daddr = 0`, `dwdata = 0`, `dwstrb = 0` and `busy = 0`. The timeout counter is cleared.
- Reset in REQ or WAIT abandons the transaction with no `memack`. A `drvalid` arriving after reset, while the FSM is in IDLE, is ignored.
- All outputs are registered.
- `memreq` in cycle 0 gives:
  - `dvalid = 1` from cycle 1;
  - for an out-of-range address, `memack` in cycle 1 and `dvalid` never asserted.
- Handshake and completion:
  - `daddr`, `dwr`, `dwdata` and `dwstrb` stay stable while `dvalid = 1`.
  - `dvalid` falls in the cycle after `dready` is sampled high.
  - `drvalid` in cycle k gives `memack` in cycle k+1.
  - `drvalid` in the same cycle as the accept is not legal.
  - Minimum in-range latency is `memreq` in cycle 0, `dready` in cycle 1, `drvalid` in cycle 2 and `memack` in cycle 3.
- Timeout: with `dready` held low, `dvalid` is high for exactly `TIMEOUT` cycles (cycles 1..`TIMEOUT`), and `memack` with `memerr = 1` comes in cycle `TIMEOUT + 1`.
- `memack` is high for exactly one cycle per accepted `memreq`. A new `memreq` is accepted in the cycle after `memack`.

## Test plan
- Read, `memaddr = 22'o1000` (0x200), `dready` high in cycle 1, `drvalid` in cycle 2 with `drdata = 32'hDEADBEEF`, `derr = 0`. Required: `daddr = 20'h80`, `dwr = 0`, `dwstrb = 0`, then `memack` in cycle 3 with `memrdata = 16'hBEEF` and `memerr = 0`.
- Write, `memaddr = 22'h202`, `memwdata = 16'h1234`, `memwstrb = 2'b01`. Required: `daddr = 20'h80`, `dwdata = 32'h12341234`, `dwstrb = 4'b0100`, `dwr = 1`; `memack` arrives one cycle after `drvalid`.
- Out-of-range, `MEMTOP` = 22'h100000, read at 22'h100000. Required: `dvalid` never asserted, `memack` in cycle 1 with `memerr = 1` and `memrdata = 0`. Then a read at 22'hFFFFE must complete normally with `memrdata = drdata[31:16]`.
- Timeout, `TIMEOUT` = 8, `dready` held low. Required: `dvalid` high for exactly 8 cycles, `memack` with `memerr = 1` in cycle 9. A later `dready` pulse in IDLE must have no effect.
- Downstream error: `drvalid` with `derr = 1` gives `memack` with `memerr = 1`. A second `memreq` issued during WAIT is ignored: exactly one `memack` and one downstream request.
- Reset mid-transaction: drop `rstn` in WAIT. Required: all outputs are reset values on the next cycle; the late `drvalid` produces no `memack`; the next `memreq` completes normally.

Source files
------------

// File: rtl/j11memctl.sv
// j11memctl: memory-side responder for the J11 bus controller memreq interface.
// Captures one 16-bit CPU cycle and range-checks its byte address. In-range cycles
// become a 32-bit word request on a valid/ready port. Out-of-range cycles and
// downstream stalls longer than TIMEOUT end in an error ack.
module j11memctl #(
  parameter logic [21:0] MEMTOP  = 22'o10000000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        memreq,
  input  logic        memwr,
  input  logic [21:0] memaddr,
  input  logic [15:0] memwdata,
  input  logic [1:0]  memwstrb,
  output logic        memack,
  output logic [15:0] memrdata,
  output logic        memerr,
  output logic        busy,
  output logic        dvalid,
  input  logic        dready,
  output logic        dwr,
  output logic [19:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwstrb,
  input  logic        drvalid,
  input  logic [31:0] drdata,
  input  logic        derr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ERR,
    S_DONE
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        h_q, h_d;
  logic        memack_q, memack_d;
  logic        memerr_q, memerr_d;
  logic [15:0] memrdata_q, memrdata_d;
  logic        busy_q, busy_d;
  logic        dvalid_q, dvalid_d;
  logic        dwr_q, dwr_d;
  logic [19:0] daddr_q, daddr_d;
  logic [31:0] dwdata_q, dwdata_d;
  logic [3:0]  dwstrb_q, dwstrb_d;

  // Next-state and next-output logic. Every output is taken from a flop, so each
  // value is computed here one cycle before it is presented.
  always_comb begin
    // NOTE: every signal gets a default here, so no path through the case
    // leaves one unassigned. An unassigned path would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    h_d        = h_q;
    memack_d   = 1'b0;
    memerr_d   = memerr_q;
    memrdata_d = memrdata_q;
    dvalid_d   = dvalid_q;
    dwr_d      = dwr_q;
    daddr_d    = daddr_q;
    dwdata_d   = dwdata_q;
    dwstrb_d   = dwstrb_q;

    unique case (state_q)
      S_IDLE: begin
        if (memreq) begin
          h_d = memaddr[1];
          if (memaddr >= MEMTOP) begin
            // Non-existent memory: ack immediately and never touch the fabric.
            state_d    = S_ERR;
            memack_d   = 1'b1;
            memerr_d   = 1'b1;
            memrdata_d = 16'h0000;
          end else begin
            state_d  = S_REQ;
            cnt_d    = 8'd0;
            dvalid_d = 1'b1;
            dwr_d    = memwr;
            daddr_d  = memaddr[21:2];
            dwdata_d = {memwdata, memwdata};
            if (memwr) begin
              dwstrb_d = memaddr[1] ? {memwstrb, 2'b00} : {2'b00, memwstrb};
            end else begin
              dwstrb_d = 4'b0000;
            end
          end
        end
      end

      S_REQ: begin
        if (dready) begin
          state_d  = S_WAIT;
          dvalid_d = 1'b0;
        end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
          // The request was never committed, so it can be withdrawn here.
          state_d    = S_ERR;
          cnt_d      = cnt_q + 8'd1;
          dvalid_d   = 1'b0;
          memack_d   = 1'b1;
          memerr_d   = 1'b1;
          memrdata_d = 16'h0000;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WAIT: begin
        if (drvalid) begin
          state_d    = S_DONE;
          memack_d   = 1'b1;
          memerr_d   = derr;
          memrdata_d = h_q ? drdata[31:16] : drdata[15:0];
        end
      end

      S_ERR, S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments, so every
    // flop samples the pre-edge values no matter how the statements are ordered.
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      h_q        <= 1'b0;
      memack_q   <= 1'b0;
      memerr_q   <= 1'b0;
      memrdata_q <= 16'h0000;
      busy_q     <= 1'b0;
      dvalid_q   <= 1'b0;
      dwr_q      <= 1'b0;
      daddr_q    <= 20'h00000;
      dwdata_q   <= 32'h0000_0000;
      dwstrb_q   <= 4'b0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      h_q        <= h_d;
      memack_q   <= memack_d;
      memerr_q   <= memerr_d;
      memrdata_q <= memrdata_d;
      busy_q     <= busy_d;
      dvalid_q   <= dvalid_d;
      dwr_q      <= dwr_d;
      daddr_q    <= daddr_d;
      dwdata_q   <= dwdata_d;
      dwstrb_q   <= dwstrb_d;
    end
  end

  assign memack   = memack_q;
  assign memerr   = memerr_q;
  assign memrdata = memrdata_q;
  assign busy     = busy_q;
  assign dvalid   = dvalid_q;
  assign dwr      = dwr_q;
  assign daddr    = daddr_q;
  assign dwdata   = dwdata_q;
  assign dwstrb   = dwstrb_q;

endmodule

// File: tb/tb_j11memctl.sv
// Bench for j11memctl. Directed cycle-exact scenarios are followed by a
// randomized phase. In that phase a byte-addressed reference memory predicts
// every ack, and a word-wide responder memory serves the downstream port.
module tb_j11memctl;

  localparam logic [21:0] MEMTOP  = 22'h100000;
  localparam int          TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rstn, memreq, memwr;
  logic [21:0] memaddr;
  logic [15:0] memwdata;
  logic [1:0]  memwstrb;
  logic        memack, memerr, busy, dvalid, dwr;
  logic [15:0] memrdata;
  logic [19:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwstrb;
  logic        dready, drvalid, derr;
  logic [31:0] drdata;

  // Downstream inputs come from the manual driver or from the random responder.
  bit          resp_on = 1'b0;
  logic        man_dready, man_drvalid, man_derr;
  logic [31:0] man_drdata;
  logic        rsp_dready, rsp_drvalid, rsp_derr;
  logic [31:0] rsp_drdata;
  assign dready  = resp_on ? rsp_dready  : man_dready;
  assign drvalid = resp_on ? rsp_drvalid : man_drvalid;
  assign derr    = resp_on ? rsp_derr    : man_derr;
  assign drdata  = resp_on ? rsp_drdata  : man_drdata;

  j11memctl #(.MEMTOP(MEMTOP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .memreq(memreq), .memwr(memwr), .memaddr(memaddr),
    .memwdata(memwdata), .memwstrb(memwstrb), .memack(memack), .memrdata(memrdata),
    .memerr(memerr), .busy(busy), .dvalid(dvalid), .dready(dready), .dwr(dwr),
    .daddr(daddr), .dwdata(dwdata), .dwstrb(dwstrb), .drvalid(drvalid),
    .drdata(drdata), .derr(derr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic err; logic [15:0] rdata; } ack_t;
  typedef struct packed { logic [19:0] addr; logic wr; logic [31:0] wdata; logic [3:0] strb; } dreq_t;

  ack_t  exp_ack[$];
  dreq_t exp_dreq[$];
  bit    derr_plan[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ---------------- reference and responder memories ----------------
  logic [7:0]  ref_b [logic [21:0]];
  logic [31:0] dmem  [logic [19:0]];

  function automatic logic [31:0] def_word(input logic [19:0] w);
    return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [21:0] b);
    logic [31:0] w;
    if (ref_b.exists(b)) return ref_b[b];
    w = def_word(b[21:2]);
    return w[8*b[1:0] +: 8];
  endfunction

  function automatic logic [31:0] dmem_read(input logic [19:0] w);
    if (dmem.exists(w)) return dmem[w];
    return def_word(w);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // ---------------- monitor: pops expected acks ----------------
  initial begin
    ack_t e;
    forever begin
      @(negedge clk);
      if (memack === 1'b1) begin
        if (exp_ack.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_memack: got memack=1 expected no ack (t=%0t)", $time);
        end else begin
          e = exp_ack.pop_front();
          check("memerr", {31'b0, memerr}, {31'b0, e.err});
          check("memrdata", {16'b0, memrdata}, {16'b0, e.rdata});
        end
      end
    end
  end

  // ---------------- random-phase downstream responder ----------------
  initial begin
    dreq_t       e;
    bit          de;
    logic [31:0] w;
    int          gap, lat;
    rsp_dready = 1'b0; rsp_drvalid = 1'b0; rsp_derr = 1'b0; rsp_drdata = '0;
    forever begin
      @(negedge clk);
      if (resp_on && dvalid === 1'b1) begin
        if (exp_dreq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dvalid: got dvalid=1 expected no request (t=%0t)", $time);
        end else begin
          e   = exp_dreq.pop_front();
          de  = derr_plan.pop_front();
          gap = $urandom_range(0, 3);
          lat = $urandom_range(0, 2);
          for (int i = 0; i <= gap; i++) begin
            if (i > 0) @(negedge clk);
            check("dvalid_held", {31'b0, dvalid}, 32'd1);
            check("daddr", {12'b0, daddr}, {12'b0, e.addr});
            check("dwr", {31'b0, dwr}, {31'b0, e.wr});
            check("dwdata", dwdata, e.wdata);
            check("dwstrb", {28'b0, dwstrb}, {28'b0, e.strb});
          end
          rsp_dready = 1'b1;
          @(negedge clk);
          rsp_dready = 1'b0;
          check("dvalid_dropped", {31'b0, dvalid}, 32'd0);
          repeat (lat) @(negedge clk);
          w = dmem_read(e.addr);
          rsp_drdata  = w;
          rsp_derr    = de;
          rsp_drvalid = 1'b1;
          if (e.wr && !de) dmem[e.addr] = merge(w, e.wdata, e.strb);
          @(negedge clk);
          rsp_drvalid = 1'b0;
          rsp_derr    = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 64) begin
      step();
      n++;
    end
    check("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  // Random-phase request; the expectation comes from the byte reference memory.
  task automatic issue(input bit wr, input logic [21:0] a, input logic [15:0] wd,
                       input logic [1:0] ws, input bit de);
    ack_t        e;
    dreq_t       r;
    logic [21:0] lo, hi;
    wait_idle();
    lo = {a[21:1], 1'b0};
    hi = {a[21:1], 1'b1};
    if (a >= MEMTOP) begin
      e.err   = 1'b1;
      e.rdata = 16'h0000;
    end else begin
      r.addr  = a[21:2];
      r.wr    = wr;
      r.wdata = {wd, wd};
      r.strb  = wr ? (4'(ws) << (2 * a[1])) : 4'b0000;
      exp_dreq.push_back(r);
      derr_plan.push_back(de);
      e.err   = de;
      e.rdata = {ref_byte(hi), ref_byte(lo)};
      if (wr && !de) begin
        if (ws[0]) ref_b[lo] = wd[7:0];
        if (ws[1]) ref_b[hi] = wd[15:8];
      end
    end
    exp_ack.push_back(e);
    memreq = 1'b1; memwr = wr; memaddr = a; memwdata = wd; memwstrb = ws;
    step();
    memreq = 1'b0;
  endtask

  // Directed minimum-latency transaction with hand-written expectations.
  task automatic man_txn(input string tag, input bit wr, input logic [21:0] a,
                         input logic [15:0] wd, input logic [1:0] ws,
                         input logic [19:0] x_addr, input logic [31:0] x_wdata,
                         input logic [3:0] x_strb, input logic [31:0] rd,
                         input bit de, input logic [15:0] x_rdata);
    ack_t e;
    wait_idle();
    e.err = de;
    e.rdata = x_rdata;
    exp_ack.push_back(e);
    memreq = 1'b1; memwr = wr; memaddr = a; memwdata = wd; memwstrb = ws;
    step();                                   // cycle 1
    memreq = 1'b0;
    check({tag, "_dvalid_c1"}, {31'b0, dvalid}, 32'd1);
    check({tag, "_daddr"}, {12'b0, daddr}, {12'b0, x_addr});
    check({tag, "_dwr"}, {31'b0, dwr}, {31'b0, wr});
    check({tag, "_dwdata"}, dwdata, x_wdata);
    check({tag, "_dwstrb"}, {28'b0, dwstrb}, {28'b0, x_strb});
    man_dready = 1'b1;
    step();                                   // cycle 2
    man_dready = 1'b0;
    check({tag, "_dvalid_c2"}, {31'b0, dvalid}, 32'd0);
    check({tag, "_memack_c2"}, {31'b0, memack}, 32'd0);
    man_drvalid = 1'b1; man_drdata = rd; man_derr = de;
    step();                                   // cycle 3
    man_drvalid = 1'b0; man_derr = 1'b0;
    check({tag, "_memack_c3"}, {31'b0, memack}, 32'd1);
    check({tag, "_memrdata_c3"}, {16'b0, memrdata}, {16'b0, x_rdata});
    step();                                   // cycle 4
    check({tag, "_memack_c4"}, {31'b0, memack}, 32'd0);
    check({tag, "_busy_c4"}, {31'b0, busy}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ack_t e;
    int   dv_cnt, ack_cnt, ack_cyc;
    rstn = 1'b0; memreq = 1'b0; memwr = 1'b0; memaddr = '0; memwdata = '0; memwstrb = '0;
    man_dready = 1'b0; man_drvalid = 1'b0; man_derr = 1'b0; man_drdata = '0;

    // Reset state.
    repeat (3) step();
    check("rst_memack", {31'b0, memack}, 32'd0);
    check("rst_memerr", {31'b0, memerr}, 32'd0);
    check("rst_memrdata", {16'b0, memrdata}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_dvalid", {31'b0, dvalid}, 32'd0);
    check("rst_dwr", {31'b0, dwr}, 32'd0);
    check("rst_daddr", {12'b0, daddr}, 32'd0);
    check("rst_dwdata", dwdata, 32'd0);
    check("rst_dwstrb", {28'b0, dwstrb}, 32'd0);
    rstn = 1'b1;
    step();

    // Read at 0x200, low halfword.
    man_txn("rd200", 1'b0, 22'o1000, 16'h0000, 2'b00, 20'h80, 32'h0, 4'b0000,
            32'hDEADBEEF, 1'b0, 16'hBEEF);
    // Write at 0x202, low byte of the upper halfword.
    man_txn("wr202", 1'b1, 22'h202, 16'h1234, 2'b01, 20'h80, 32'h12341234, 4'b0100,
            32'hCAFEF00D, 1'b0, 16'hCAFE);
    // Write at 0x0, high byte of the lower halfword.
    man_txn("wr000", 1'b1, 22'h0, 16'hABCD, 2'b10, 20'h0, 32'hABCDABCD, 4'b0010,
            32'h01020304, 1'b0, 16'h0304);

    // Out-of-range read at MEMTOP.
    wait_idle();
    e.err = 1'b1; e.rdata = 16'h0000;
    exp_ack.push_back(e);
    memreq = 1'b1; memwr = 1'b0; memaddr = 22'h100000;
    step();
    memreq = 1'b0;
    check("oor_memack_c1", {31'b0, memack}, 32'd1);
    check("oor_dvalid_c1", {31'b0, dvalid}, 32'd0);
    step();
    check("oor_memack_c2", {31'b0, memack}, 32'd0);
    check("oor_dvalid_c2", {31'b0, dvalid}, 32'd0);
    // Last in-range halfword.
    man_txn("rdtop", 1'b0, 22'hFFFFE, 16'h0000, 2'b00, 20'h3FFFF, 32'h0, 4'b0000,
            32'h5A5A1111, 1'b0, 16'h5A5A);

    // Timeout with dready held low.
    wait_idle();
    e.err = 1'b1; e.rdata = 16'h0000;
    exp_ack.push_back(e);
    memreq = 1'b1; memwr = 1'b0; memaddr = 22'h10;
    step();
    memreq = 1'b0;
    dv_cnt = 0; ack_cyc = -1;
    for (int c = 1; c <= 14; c++) begin
      if (dvalid === 1'b1) dv_cnt++;
      if (memack === 1'b1 && ack_cyc < 0) ack_cyc = c;
      step();
    end
    check("tmo_dvalid_cycles", dv_cnt, TIMEOUT);
    check("tmo_ack_cycle", ack_cyc, TIMEOUT + 1);
    // Stray handshake in IDLE must do nothing.
    man_dready = 1'b1; man_drvalid = 1'b1; man_drdata = 32'h12345678;
    step();
    man_dready = 1'b0; man_drvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("idle_stray_memack", {31'b0, memack}, 32'd0);
      check("idle_stray_busy", {31'b0, busy}, 32'd0);
      step();
    end

    // Downstream error, with a second memreq issued during WAIT.
    wait_idle();
    e.err = 1'b1; e.rdata = 16'h7777;
    exp_ack.push_back(e);
    memreq = 1'b1; memwr = 1'b0; memaddr = 22'h400;
    step();
    dv_cnt = 0; ack_cnt = 0;
    for (int c = 1; c <= 14; c++) begin
      if (dvalid === 1'b1) dv_cnt++;
      if (memack === 1'b1) ack_cnt++;
      memreq = 1'b0; man_dready = 1'b0; man_drvalid = 1'b0; man_derr = 1'b0;
      if (c == 1) man_dready = 1'b1;
      if (c == 2) begin memreq = 1'b1; memaddr = 22'h3000; end
      if (c == 3) begin man_drvalid = 1'b1; man_derr = 1'b1; man_drdata = 32'h88887777; end
      step();
    end
    check("derr_dvalid_cycles", dv_cnt, 1);
    check("derr_ack_count", ack_cnt, 1);

    // Reset while in WAIT.
    wait_idle();
    memreq = 1'b1; memwr = 1'b0; memaddr = 22'h800;
    step();
    memreq = 1'b0; man_dready = 1'b1;
    step();
    man_dready = 1'b0; rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("mrst_memack", {31'b0, memack}, 32'd0);
    check("mrst_memerr", {31'b0, memerr}, 32'd0);
    check("mrst_memrdata", {16'b0, memrdata}, 32'd0);
    check("mrst_busy", {31'b0, busy}, 32'd0);
    check("mrst_dvalid", {31'b0, dvalid}, 32'd0);
    check("mrst_dwr", {31'b0, dwr}, 32'd0);
    check("mrst_daddr", {12'b0, daddr}, 32'd0);
    check("mrst_dwdata", dwdata, 32'd0);
    check("mrst_dwstrb", {28'b0, dwstrb}, 32'd0);
    man_drvalid = 1'b1; man_drdata = 32'hFFFFFFFF;
    step();
    man_drvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("late_drvalid_memack", {31'b0, memack}, 32'd0);
      step();
    end
    man_txn("afterrst", 1'b0, 22'h802, 16'h0000, 2'b00, 20'h200, 32'h0, 4'b0000,
            32'h13572468, 1'b0, 16'h1357);

    // Randomized phase against the reference memory.
    wait_idle();
    resp_on = 1'b1;
    for (int t = 0; t < 120; t++) begin
      logic [21:0] a;
      case ($urandom_range(0, 3))
        0, 1:    a = 22'($urandom_range(0, 63));
        2:       a = MEMTOP - 22'd16 + 22'($urandom_range(0, 31));
        default: a = 22'($urandom);
      endcase
      issue(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0);
    end
    wait_idle();
    repeat (6) step();
    check("ack_queue_drained", exp_ack.size(), 0);
    check("dreq_queue_drained", exp_dreq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
